// File: rtl/alu_uart_loader_if.sv
// Bundle between the UART/ALU side and the loader sequencer.
// master: loader (drives ALU inputs and TX request); slave: UART/ALU side.
interface alu_uart_loader_if #(
   parameter int NB_DATA = 8,
   parameter int NB_ALU  = 6,
   parameter int NB_OP   = 6
);
   logic               i_rx_done;
   logic [NB_DATA-1:0] i_rx_data;
   logic [NB_ALU-1:0]  i_alu_res;
   logic               i_tx_busy;
   logic [NB_ALU-1:0]  o_alu_a;
   logic [NB_ALU-1:0]  o_alu_b;
   logic [NB_OP-1:0]   o_alu_op;
   logic               o_tx_start;
   logic [NB_DATA-1:0] o_tx_data;
   logic               o_op_err;
   logic               o_overrun;

   modport master (
      input  i_rx_done, i_rx_data, i_alu_res, i_tx_busy,
      output o_alu_a, o_alu_b, o_alu_op,
      output o_tx_start, o_tx_data, o_op_err, o_overrun
   );

   modport slave (
      output i_rx_done, i_rx_data, i_alu_res, i_tx_busy,
      input  o_alu_a, o_alu_b, o_alu_op,
      input  o_tx_start, o_tx_data, o_op_err, o_overrun
   );
endinterface

// File: rtl/alu_uart_loader.sv
// Sequencer: UART bytes A, B, opcode -> registered ALU inputs -> TX byte.
// Ports: i_clk, i_rst_n (async low), bus (alu_uart_loader_if.master).
module alu_uart_loader #(
   parameter int NB_DATA = 8,
   parameter int NB_ALU  = 6,
   parameter int NB_OP   = 6
) (
   input logic              i_clk,
   input logic              i_rst_n,
   alu_uart_loader_if.master bus
);
   localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(8'h20);
   localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(8'h22);
   localparam logic [NB_OP-1:0] OP_AND = NB_OP'(8'h24);
   localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(8'h25);
   localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(8'h26);
   localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(8'h27);
   localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(8'h03);
   localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(8'h02);

   typedef enum logic [2:0] {
      S_A, S_B, S_OP, S_EXEC, S_SEND
   } state_t;

   state_t             state, state_d;
   logic [NB_OP-1:0]   rx_op;
   logic               op_ok;
   logic               busy_state;
   logic [NB_ALU-1:0]  a_d, b_d;
   logic [NB_OP-1:0]   op_d;
   logic [NB_DATA-1:0] txd_d;
   logic               start_d, err_d, ovr_d;
   logic               unused_ok;

   // Upper rx bits are ignored by design.
   assign unused_ok = &{1'b0, bus.i_rx_data};

   assign rx_op = bus.i_rx_data[NB_OP-1:0];
   assign busy_state = (state == S_EXEC) || (state == S_SEND);

   always_comb begin
      op_ok = 1'b0;
      case (rx_op)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_XOR, OP_NOR, OP_SRA, OP_SRL: op_ok = 1'b1;
         default:                        op_ok = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= S_A;
      else          state <= state_d;
   end

   always_comb begin
      state_d = state;
      unique case (state)
         S_A:    if (bus.i_rx_done) state_d = S_B;
         S_B:    if (bus.i_rx_done) state_d = S_OP;
         S_OP:   if (bus.i_rx_done && op_ok) state_d = S_EXEC;
         S_EXEC: state_d = S_SEND;
         S_SEND: if (!bus.i_tx_busy) state_d = S_A;
         default: state_d = S_A;
      endcase
   end

   always_comb begin
      a_d     = bus.o_alu_a;
      b_d     = bus.o_alu_b;
      op_d    = bus.o_alu_op;
      txd_d   = bus.o_tx_data;
      start_d = 1'b0;
      err_d   = 1'b0;
      ovr_d   = bus.o_overrun | (bus.i_rx_done & busy_state);
      unique case (state)
         S_A: if (bus.i_rx_done)
            a_d = bus.i_rx_data[NB_ALU-1:0];
         S_B: if (bus.i_rx_done)
            b_d = bus.i_rx_data[NB_ALU-1:0];
         S_OP: if (bus.i_rx_done) begin
            if (op_ok) op_d  = rx_op;
            else       err_d = 1'b1;
         end
         // ALU has had one full cycle on stable inputs here.
         S_EXEC: txd_d = NB_DATA'($signed(bus.i_alu_res));
         S_SEND: start_d = !bus.i_tx_busy;
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bus.o_alu_a    <= '0;
         bus.o_alu_b    <= '0;
         bus.o_alu_op   <= '0;
         bus.o_tx_data  <= '0;
         bus.o_tx_start <= 1'b0;
         bus.o_op_err   <= 1'b0;
         bus.o_overrun  <= 1'b0;
      end else begin
         bus.o_alu_a    <= a_d;
         bus.o_alu_b    <= b_d;
         bus.o_alu_op   <= op_d;
         bus.o_tx_data  <= txd_d;
         bus.o_tx_start <= start_d;
         bus.o_op_err   <= err_d;
         bus.o_overrun  <= ovr_d;
      end
   end
endmodule

// File: tb/tb_alu_uart_loader.sv
// Directed bench for alu_uart_loader with a behavioural ALU model.
// Each task drives one scenario and checks its own results.
module tb_alu_uart_loader;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   alu_uart_loader_if #(.NB_DATA(8), .NB_ALU(6), .NB_OP(6)) bus ();

   alu_uart_loader #(.NB_DATA(8), .NB_ALU(6), .NB_OP(6)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU, 6-bit.
   always_comb begin
      logic signed [5:0] sa;
      sa = $signed(bus.o_alu_a);
      case (bus.o_alu_op)
         6'h20:   bus.i_alu_res = bus.o_alu_a + bus.o_alu_b;
         6'h22:   bus.i_alu_res = bus.o_alu_a - bus.o_alu_b;
         6'h24:   bus.i_alu_res = bus.o_alu_a & bus.o_alu_b;
         6'h25:   bus.i_alu_res = bus.o_alu_a | bus.o_alu_b;
         6'h26:   bus.i_alu_res = bus.o_alu_a ^ bus.o_alu_b;
         6'h27:   bus.i_alu_res = ~(bus.o_alu_a | bus.o_alu_b);
         6'h03:   bus.i_alu_res = sa >>> bus.o_alu_b;
         6'h02:   bus.i_alu_res = bus.o_alu_a >> bus.o_alu_b;
         default: bus.i_alu_res = 6'h00;
      endcase
   end

   task automatic send_now(input logic [7:0] b);
      bus.i_rx_done = 1'b1;
      bus.i_rx_data = b;
      @(posedge clk); #1;
      bus.i_rx_done = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      send_now(b);
   endtask

   task automatic wait_tx(output bit seen, output int n);
      seen = 1'b0;
      n = 0;
      while (!seen && n < 50) begin
         if (bus.o_tx_start === 1'b1) seen = 1'b1;
         else begin
            @(posedge clk); #1;
            n++;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bus.i_rx_done = 1'b0;
      bus.i_rx_data = 8'h00;
      bus.i_tx_busy = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_tx_data,
           bus.o_tx_start, bus.o_op_err, bus.o_overrun} !== 35'h0) begin
         errors++;
         $display("FAIL reset: outputs %h, expected 0",
                  {bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_tx_data});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_add;
      bit seen;
      int n;
      send_byte(8'h02);
      send_byte(8'h03);
      send_byte(8'h20);
      checks++;
      if ({bus.o_alu_a, bus.o_alu_b, bus.o_alu_op} !== {6'h02, 6'h03, 6'h20}) begin
         errors++;
         $display("FAIL add_inputs: got %h %h %h expected 02 03 20",
                  bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);
      end
      wait_tx(seen, n);
      checks++;
      if (!seen || n != 2) begin
         errors++;
         $display("FAIL add_latency: seen %0d after %0d edges, expected 2", seen, n);
      end
      checks++;
      if (bus.o_tx_data !== 8'h05) begin
         errors++;
         $display("FAIL add_data: got %h expected 05", bus.o_tx_data);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.o_tx_start !== 1'b0) begin
         errors++;
         $display("FAIL add_strobe_width: got %b expected 0", bus.o_tx_start);
      end
   endtask

   task automatic test_sub_sign;
      bit seen;
      int n;
      send_byte(8'h02);
      send_byte(8'h05);
      send_byte(8'h22);
      wait_tx(seen, n);
      checks++;
      if (!seen || bus.o_tx_data !== 8'hFD) begin
         errors++;
         $display("FAIL sub_sign: seen %0d data %h expected FD", seen, bus.o_tx_data);
      end
   endtask

   task automatic test_op_err;
      bit seen;
      int n;
      bit early;
      send_byte(8'h07);
      send_byte(8'h07);
      send_byte(8'h3F);
      checks++;
      if (bus.o_op_err !== 1'b1 || bus.o_alu_op !== 6'h22) begin
         errors++;
         $display("FAIL op_err_pulse: err %b op %h expected 1 22",
                  bus.o_op_err, bus.o_alu_op);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.o_op_err !== 1'b0) begin
         errors++;
         $display("FAIL op_err_width: got %b expected 0", bus.o_op_err);
      end
      early = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (bus.o_tx_start !== 1'b0) early = 1'b1;
      end
      checks++;
      if (early) begin
         errors++;
         $display("FAIL op_err_stay: tx_start 1 expected 0");
      end
      send_byte(8'h24);
      wait_tx(seen, n);
      checks++;
      if (!seen || bus.o_tx_data !== 8'h07 || bus.o_alu_a !== 6'h07) begin
         errors++;
         $display("FAIL op_err_retry: seen %0d data %h expected 07", seen, bus.o_tx_data);
      end
   endtask

   task automatic test_busy_overrun;
      bit early;
      bus.i_tx_busy = 1'b1;
      send_byte(8'h01);
      send_byte(8'h01);
      checks++;
      if (bus.o_overrun !== 1'b0) begin
         errors++;
         $display("FAIL overrun_clear: got %b expected 0", bus.o_overrun);
      end
      send_byte(8'h20);
      early = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i == 5) begin
            bus.i_rx_done = 1'b1;
            bus.i_rx_data = 8'h11;
         end
         @(posedge clk); #1;
         bus.i_rx_done = 1'b0;
         if (bus.o_tx_start !== 1'b0) early = 1'b1;
      end
      checks++;
      if (early) begin
         errors++;
         $display("FAIL busy_hold: tx_start 1 while busy, expected 0");
      end
      checks++;
      if (bus.o_overrun !== 1'b1 || bus.o_alu_a !== 6'h01) begin
         errors++;
         $display("FAIL overrun_set: ovr %b a %h expected 1 01",
                  bus.o_overrun, bus.o_alu_a);
      end
      bus.i_tx_busy = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus.o_tx_start !== 1'b1 || bus.o_tx_data !== 8'h02) begin
         errors++;
         $display("FAIL busy_release: start %b data %h expected 1 02",
                  bus.o_tx_start, bus.o_tx_data);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.o_tx_start !== 1'b0 || bus.o_overrun !== 1'b1) begin
         errors++;
         $display("FAIL busy_after: start %b ovr %b expected 0 1",
                  bus.o_tx_start, bus.o_overrun);
      end
   endtask

   task automatic test_mid_reset;
      bit seen;
      int n;
      send_byte(8'h0A);
      send_byte(8'h0B);
      rst_n = 1'b0;
      #2;
      checks++;
      if ({bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_tx_data,
           bus.o_tx_start, bus.o_op_err, bus.o_overrun} !== 35'h0) begin
         errors++;
         $display("FAIL mid_reset: a %h b %h ovr %b expected 0",
                  bus.o_alu_a, bus.o_alu_b, bus.o_overrun);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      send_byte(8'h0F);
      send_byte(8'h01);
      send_byte(8'h03);
      wait_tx(seen, n);
      checks++;
      if (!seen || bus.o_tx_data !== 8'h07) begin
         errors++;
         $display("FAIL mid_reset_sra: seen %0d data %h expected 07", seen, bus.o_tx_data);
      end
   endtask

   task automatic test_back_to_back;
      bit seen;
      int n;
      send_byte(8'h05);
      send_byte(8'h02);
      send_byte(8'hE0);
      checks++;
      if (bus.o_alu_op !== 6'h20 || bus.o_op_err !== 1'b0) begin
         errors++;
         $display("FAIL high_bits: op %h err %b expected 20 0",
                  bus.o_alu_op, bus.o_op_err);
      end
      wait_tx(seen, n);
      checks++;
      if (!seen || bus.o_tx_data !== 8'h07) begin
         errors++;
         $display("FAIL b2b_first: seen %0d data %h expected 07", seen, bus.o_tx_data);
      end
      send_now(8'h3F);
      checks++;
      if (bus.o_alu_a !== 6'h3F) begin
         errors++;
         $display("FAIL b2b_accept: a %h expected 3F", bus.o_alu_a);
      end
      send_byte(8'h01);
      send_byte(8'h03);
      wait_tx(seen, n);
      checks++;
      if (!seen || n != 2 || bus.o_tx_data !== 8'hFF) begin
         errors++;
         $display("FAIL b2b_second: seen %0d n %0d data %h expected FF",
                  seen, n, bus.o_tx_data);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_add();
      test_sub_sign();
      test_op_err();
      test_busy_overrun();
      test_mid_reset();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
